// File: rtl/branch_commit_queue_if.sv
// Bundles the decode, resolve, commit and flush signals of branch_commit_queue.
// The queue takes the slave modport. Producers and consumers take the master modport.
interface branch_commit_queue_if #(
   parameter int TAG_W = 4
);
   logic             alloc_valid;
   logic [31:0]      alloc_pc;
   logic [5:0]       alloc_op;
   logic [2:0]       alloc_op_type;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_tag;
   logic             resolve_valid;
   logic [TAG_W-1:0] resolve_tag;
   logic             resolve_taken;
   logic [31:0]      resolve_target;
   logic             rob_commit;
   logic [31:0]      rob_pc_commit;
   logic [5:0]       rob_op_commit;
   logic [2:0]       rob_op_type;
   logic [31:0]      rob_result;
   logic [31:0]      rob_pc_result;
   logic             roll_back;
   logic [TAG_W:0]   count;

   modport master (
      output alloc_valid, alloc_pc, alloc_op, alloc_op_type,
      output resolve_valid, resolve_tag, resolve_taken, resolve_target, roll_back,
      input  alloc_ready, alloc_tag, rob_commit, rob_pc_commit, rob_op_commit,
      input  rob_op_type, rob_result, rob_pc_result, count
   );

   modport slave (
      input  alloc_valid, alloc_pc, alloc_op, alloc_op_type,
      input  resolve_valid, resolve_tag, resolve_taken, resolve_target, roll_back,
      output alloc_ready, alloc_tag, rob_commit, rob_pc_commit, rob_op_commit,
      output rob_op_type, rob_result, rob_pc_result, count
   );
endinterface

// File: rtl/branch_commit_queue.sv
// In-order commit queue for control-flow instructions. Entries are allocated in order and resolved out of order by tag.
// Entries retire in program order and produce one rob_* commit pulse each. A roll_back from the predictor flushes the queue.
module branch_commit_queue #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic rdy_in,
   branch_commit_queue_if.slave bus
);
   localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0] valid_q, done_q, taken_q;
   logic [31:0]      pc_q     [DEPTH];
   logic [5:0]       op_q     [DEPTH];
   logic [2:0]       type_q   [DEPTH];
   logic [31:0]      target_q [DEPTH];
   logic [TAG_W-1:0] head, tail;
   logic [TAG_W:0]   count_q;

   logic        commit_q, taken_out_q;
   logic [31:0] pc_out_q, target_out_q;
   logic [5:0]  op_out_q;
   logic [2:0]  type_out_q;

   logic flush, do_alloc, do_resolve, do_commit;

   assign bus.alloc_ready = rdy_in && (count_q < FULL);
   assign bus.alloc_tag   = tail;
   assign bus.count       = count_q;

   assign flush      = rdy_in && bus.roll_back;
   assign do_alloc   = bus.alloc_valid && bus.alloc_ready && !bus.roll_back;
   assign do_resolve = bus.resolve_valid && rdy_in && !bus.roll_back && valid_q[bus.resolve_tag];
   assign do_commit  = valid_q[head] && done_q[head] && rdy_in && !bus.roll_back;

   assign bus.rob_commit    = commit_q;
   assign bus.rob_pc_commit = pc_out_q;
   assign bus.rob_op_commit = op_out_q;
   assign bus.rob_op_type   = type_out_q;
   assign bus.rob_result    = {31'b0, taken_out_q};
   assign bus.rob_pc_result = target_out_q;

   // The commit clear comes after the resolve set, so a resolve that hits the retiring head has no effect.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         valid_q      <= '0;
         done_q       <= '0;
         head         <= '0;
         tail         <= '0;
         count_q      <= '0;
         commit_q     <= 1'b0;
         pc_out_q     <= '0;
         op_out_q     <= '0;
         type_out_q   <= '0;
         taken_out_q  <= 1'b0;
         target_out_q <= '0;
      end else begin
         commit_q <= 1'b0;
         if (flush) begin
            valid_q <= '0;
            done_q  <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
         end else if (rdy_in) begin
            if (do_resolve) done_q[bus.resolve_tag] <= 1'b1;
            if (do_alloc) begin
               valid_q[tail] <= 1'b1;
               done_q[tail]  <= 1'b0;
               tail          <= tail + 1'b1;
            end
            if (do_commit) begin
               valid_q[head] <= 1'b0;
               done_q[head]  <= 1'b0;
               head          <= head + 1'b1;
               commit_q      <= 1'b1;
               pc_out_q      <= pc_q[head];
               op_out_q      <= op_q[head];
               type_out_q    <= type_q[head];
               taken_out_q   <= taken_q[head];
               target_out_q  <= target_q[head];
            end
            count_q <= count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
         end
      end
   end

   // The payload is read only while the matching valid/done bits are set, so it has no reset.
   always_ff @(posedge clk_in) begin
      if (do_alloc) begin
         pc_q[tail]   <= bus.alloc_pc;
         op_q[tail]   <= bus.alloc_op;
         type_q[tail] <= bus.alloc_op_type;
      end
      if (do_resolve) begin
         taken_q[bus.resolve_tag]  <= bus.resolve_taken;
         target_q[bus.resolve_tag] <= bus.resolve_target;
      end
   end
endmodule

// File: tb/tb_branch_commit_queue.sv
// Directed bench for branch_commit_queue with hand-computed expectations.
// It covers ordering, the full and wrap boundaries, back-to-back commits, roll back, stall and asynchronous reset.
module tb_branch_commit_queue;
   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic rdy_in = 1'b1;
   int   checks = 0;
   int   errors = 0;

   branch_commit_queue_if #(.TAG_W(4)) bus ();

   branch_commit_queue #(.DEPTH(16), .TAG_W(4)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alloc_valid    = 1'b0;
      bus.alloc_pc       = '0;
      bus.alloc_op       = '0;
      bus.alloc_op_type  = '0;
      bus.resolve_valid  = 1'b0;
      bus.resolve_tag    = '0;
      bus.resolve_taken  = 1'b0;
      bus.resolve_target = '0;
      bus.roll_back      = 1'b0;
   endtask

   task automatic alloc_one(input logic [31:0] pc, input logic [2:0] op_type);
      bus.alloc_valid   = 1'b1;
      bus.alloc_pc      = pc;
      bus.alloc_op      = 6'h18;
      bus.alloc_op_type = op_type;
      step();
      bus.alloc_valid   = 1'b0;
   endtask

   task automatic resolve_one(input logic [3:0] tag, input logic taken, input logic [31:0] target);
      bus.resolve_valid  = 1'b1;
      bus.resolve_tag    = tag;
      bus.resolve_taken  = taken;
      bus.resolve_target = target;
      step();
      bus.resolve_valid  = 1'b0;
   endtask

   task automatic expect_commit(input string tag, input logic [31:0] pc, input logic taken,
                                input logic [31:0] target);
      check({tag, "_commit"}, 64'(bus.rob_commit), 64'd1);
      check({tag, "_pc"}, 64'(bus.rob_pc_commit), 64'(pc));
      check({tag, "_result"}, 64'(bus.rob_result), 64'(taken));
      check({tag, "_target"}, 64'(bus.rob_pc_result), 64'(target));
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      step();
      rst_in = 1'b1;
      step();
   endtask

   initial begin
      idle_inputs();
      #3;
      check("rst_commit", 64'(bus.rob_commit), 64'd0);
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_tag", 64'(bus.alloc_tag), 64'd0);
      check("rst_ready", 64'(bus.alloc_ready), 64'd1);
      check("rst_pc", 64'(bus.rob_pc_commit), 64'd0);
      rdy_in = 1'b0;
      #1;
      check("rst_ready_rdy0", 64'(bus.alloc_ready), 64'd0);
      rdy_in = 1'b1;
      step();
      rst_in = 1'b1;
      step();

      // Three entries resolved out of order must still commit in PC order.
      alloc_one(32'h00, 3'd1);
      alloc_one(32'h10, 3'd1);
      alloc_one(32'h20, 3'd1);
      check("ord_count", 64'(bus.count), 64'd3);
      resolve_one(4'd2, 1'b1, 32'h40);
      check("ord_nocommit", 64'(bus.rob_commit), 64'd0);
      resolve_one(4'd0, 1'b0, 32'h14);
      check("ord_nocommit2", 64'(bus.rob_commit), 64'd0);
      resolve_one(4'd1, 1'b1, 32'h80);
      expect_commit("ord0", 32'h00, 1'b0, 32'h14);
      step();
      expect_commit("ord1", 32'h10, 1'b1, 32'h80);
      step();
      expect_commit("ord2", 32'h20, 1'b1, 32'h40);
      step();
      check("ord_idle", 64'(bus.rob_commit), 64'd0);
      check("ord_count0", 64'(bus.count), 64'd0);

      // Fill all 16 entries, then resolve them in reverse so that 16 commits follow back to back.
      do_reset();
      for (int i = 0; i < 16; i++) alloc_one(32'h1000 + 32'(4 * i), 3'(i));
      check("full_ready", 64'(bus.alloc_ready), 64'd0);
      check("full_count", 64'(bus.count), 64'd16);
      alloc_one(32'hDEAD, 3'd7);
      check("full_drop_count", 64'(bus.count), 64'd16);
      check("full_drop_tag", 64'(bus.alloc_tag), 64'd0);
      for (int t = 15; t >= 0; t--) resolve_one(4'(t), 1'(t), 32'h3000 + 32'(8 * t));
      check("full_res_nocommit", 64'(bus.rob_commit), 64'd0);
      step();
      expect_commit("b2b_0", 32'h1000, 1'b0, 32'h3000);
      check("wrap_ready", 64'(bus.alloc_ready), 64'd1);
      check("wrap_tag", 64'(bus.alloc_tag), 64'd0);
      check("wrap_count", 64'(bus.count), 64'd15);
      for (int i = 1; i < 16; i++) begin
         step();
         expect_commit($sformatf("b2b_%0d", i), 32'h1000 + 32'(4 * i), 1'(i), 32'h3000 + 32'(8 * i));
      end
      check("b2b_count0", 64'(bus.count), 64'd0);
      step();
      check("b2b_end", 64'(bus.rob_commit), 64'd0);
      check("b2b_end_count", 64'(bus.count), 64'd0);

      // A roll_back in the cycle after the first commit must suppress the commits that follow.
      for (int i = 0; i < 4; i++) alloc_one(32'h500 + 32'(4 * i), 3'd1);
      resolve_one(4'd0, 1'b1, 32'h900);
      bus.resolve_valid = 1'b1;
      bus.resolve_tag   = 4'd1;
      step();
      expect_commit("rb_first", 32'h500, 1'b1, 32'h900);
      bus.roll_back   = 1'b1;
      bus.resolve_tag = 4'd2;
      step();
      bus.roll_back = 1'b0;
      check("rb_commit", 64'(bus.rob_commit), 64'd0);
      check("rb_count", 64'(bus.count), 64'd0);
      check("rb_tag", 64'(bus.alloc_tag), 64'd0);
      bus.resolve_tag = 4'd3;
      step();
      bus.resolve_valid = 1'b0;
      check("rb_after", 64'(bus.rob_commit), 64'd0);
      step();
      check("rb_after2", 64'(bus.rob_commit), 64'd0);
      check("rb_after_count", 64'(bus.count), 64'd0);

      // While rdy_in is low, a done head stays in the queue.
      alloc_one(32'h600, 3'd2);
      resolve_one(4'd0, 1'b0, 32'h604);
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stall_commit_%0d", i), 64'(bus.rob_commit), 64'd0);
         check($sformatf("stall_count_%0d", i), 64'(bus.count), 64'd1);
      end
      rdy_in = 1'b1;
      step();
      expect_commit("stall_release", 32'h600, 1'b0, 32'h604);
      check("stall_count_after", 64'(bus.count), 64'd0);

      // An asynchronous reset in mid-cycle must clear the queue without waiting for a clock edge.
      for (int i = 0; i < 6; i++) alloc_one(32'h700 + 32'(4 * i), 3'd1);
      resolve_one(4'd1, 1'b1, 32'hA00);
      step();
      check("ar_pre_commit", 64'(bus.rob_commit), 64'd1);
      check("ar_pre_count", 64'(bus.count), 64'd5);
      #2;
      rst_in = 1'b0;
      #1;
      check("ar_commit", 64'(bus.rob_commit), 64'd0);
      check("ar_count", 64'(bus.count), 64'd0);
      check("ar_tag", 64'(bus.alloc_tag), 64'd0);
      check("ar_pc", 64'(bus.rob_pc_commit), 64'd0);
      step();
      rst_in = 1'b1;
      step();
      check("ar_post_count", 64'(bus.count), 64'd0);
      check("ar_post_commit", 64'(bus.rob_commit), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
